// File: rtl/scanline_irq_unit_if.sv
// CPU register bus and PPU CHR-read tap seen by the scanline IRQ unit.
// The mapper core drives the master side; the IRQ unit is the slave.
interface scanline_irq_unit_if;
  logic        ce;
  logic        ppu_ce;
  logic [15:0] prg_ain;
  logic        prg_read;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic [7:0]  prg_dout;
  logic        has_dout;
  logic [13:0] chr_ain;
  logic        chr_read;

  modport master (
    output ce, ppu_ce, prg_ain, prg_read, prg_write, prg_din, chr_ain, chr_read,
    input  prg_dout, has_dout
  );

  modport slave (
    input  ce, ppu_ce, prg_ain, prg_read, prg_write, prg_din, chr_ain, chr_read,
    output prg_dout, has_dout
  );
endinterface

// File: rtl/scanline_irq_unit.sv
// Scanline counter driven by repeated nametable fetches on the CHR bus,
// with per-channel target compare, pending/enable IRQ bits and a CPU register window.
module scanline_irq_unit #(
  parameter int          CHANNELS     = 2,
  parameter int          LINE_W       = 8,
  parameter int          MATCH_COUNT  = 3,
  parameter int          IDLE_TIMEOUT = 3,
  parameter logic [15:0] BASE         = 16'h5200
) (
  input  logic                clk,
  input  logic                reset,
  scanline_irq_unit_if.slave  bus,
  output logic                in_frame,
  output logic [LINE_W-1:0]   scanline,
  output logic                irq
);

  localparam logic [1:0]        MC_TOP   = 2'(MATCH_COUNT - 1);
  localparam logic [1:0]        MC_ARM   = 2'(MATCH_COUNT - 2);
  localparam logic [3:0]        IDLE_MAX = 4'(IDLE_TIMEOUT);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  logic [1:0]                        match_cnt_q, match_cnt_d;
  logic [13:0]                       last_addr_q, last_addr_d;
  logic [3:0]                        idle_cnt_q, idle_cnt_d;
  logic                              in_frame_q, in_frame_d;
  logic [LINE_W-1:0]                 scanline_q, scanline_d;
  logic [CHANNELS-1:0]               pending_q, pending_d;
  logic [CHANNELS-1:0]               enable_q, enable_d;
  logic [CHANNELS-1:0][LINE_W-1:0]   target_q, target_d;

  logic                chr_rd, nt_repeat, line_start, idle_hit;
  logic [LINE_W-1:0]   scan_next;
  logic [CHANNELS-1:0] tgt_wr, en_wr, status_rd;
  logic [7:0]          dout;
  logic                dout_vld;

  assign chr_rd     = bus.ppu_ce & bus.chr_read;
  assign nt_repeat  = (bus.chr_ain[13:12] == 2'b10) && (bus.chr_ain == last_addr_q);
  assign line_start = chr_rd && nt_repeat && (match_cnt_q == MC_ARM);
  // Any qualified CHR read proves rendering is alive, so it always beats the timeout.
  assign idle_hit   = !chr_rd &&
                      ((bus.ce && (idle_cnt_q == IDLE_MAX - 4'd1)) || (idle_cnt_q == IDLE_MAX));
  assign scan_next  = !in_frame_q ? '0 :
                      (scanline_q == LINE_MAX) ? LINE_MAX : scanline_q + 1'b1;

  always_comb begin
    dout      = 8'hFF;
    dout_vld  = 1'b0;
    tgt_wr    = '0;
    en_wr     = '0;
    status_rd = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (bus.prg_ain == 16'(BASE + 2 * ch))
        tgt_wr[ch] = bus.ce & bus.prg_write;
      if (bus.prg_ain == 16'(BASE + 2 * ch + 1)) begin
        dout          = {pending_q[ch], in_frame_q, 6'b0};
        dout_vld      = 1'b1;
        en_wr[ch]     = bus.ce & bus.prg_write;
        status_rd[ch] = bus.ce & bus.prg_read;
      end
    end
    if (bus.prg_ain == 16'(BASE + 2 * CHANNELS)) begin
      dout     = scanline_q[7:0];
      dout_vld = 1'b1;
    end
  end

  assign bus.prg_dout = dout;
  assign bus.has_dout = dout_vld;

  always_comb begin
    match_cnt_d = match_cnt_q;
    last_addr_d = last_addr_q;
    idle_cnt_d  = idle_cnt_q;
    in_frame_d  = in_frame_q;
    scanline_d  = scanline_q;
    pending_d   = pending_q;
    enable_d    = enable_q;
    target_d    = target_q;

    if (chr_rd) begin
      last_addr_d = bus.chr_ain;
      idle_cnt_d  = 4'd0;
      if (nt_repeat)
        match_cnt_d = (match_cnt_q == MC_TOP) ? MC_TOP : match_cnt_q + 2'd1;
      else
        match_cnt_d = 2'd0;
    end else if (bus.ce && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + 4'd1;
    end

    if (idle_hit) begin
      in_frame_d  = 1'b0;
      scanline_d  = '0;
      match_cnt_d = 2'd0;
    end

    if (line_start) begin
      in_frame_d = 1'b1;
      scanline_d = scan_next;
    end

    // Clear first so a same-edge compare hit wins; compare uses the pre-write target.
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (status_rd[ch])
        pending_d[ch] = 1'b0;
      if (line_start && in_frame_q && (target_q[ch] != '0) && (target_q[ch] == scan_next))
        pending_d[ch] = 1'b1;
      if (tgt_wr[ch])
        target_d[ch] = LINE_W'(bus.prg_din);
      if (en_wr[ch])
        enable_d[ch] = bus.prg_din[7];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt_q <= 2'd0;
      last_addr_q <= 14'd0;
      idle_cnt_q  <= 4'd0;
      in_frame_q  <= 1'b0;
      scanline_q  <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      target_q    <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      last_addr_q <= last_addr_d;
      idle_cnt_q  <= idle_cnt_d;
      in_frame_q  <= in_frame_d;
      scanline_q  <= scanline_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      target_q    <= target_d;
    end
  end

  assign in_frame = in_frame_q;
  assign scanline = scanline_q;
  assign irq      = |(pending_q & enable_q);

endmodule

// File: tb/tb_scanline_irq_unit.sv
// Directed bench for scanline_irq_unit: a PPU-read vector table plus a
// register-decode table, then hand-written IRQ, masking, timeout and collision sequences.
module tb_scanline_irq_unit;
  localparam logic [15:0] BASE = 16'h5200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_frame;
  logic [7:0] scanline;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

  scanline_irq_unit_if bus_if ();

  scanline_irq_unit #(
    .CHANNELS(2), .LINE_W(8), .MATCH_COUNT(3), .IDLE_TIMEOUT(3), .BASE(BASE)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .in_frame(in_frame), .scanline(scanline), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic        exp_if;
    logic [7:0]  exp_sl;
  } ppu_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp_dout;
    logic        exp_has;
  } reg_vec_t;

  ppu_vec_t pv[12];
  reg_vec_t rv[6];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_if.ce = 1'b0; bus_if.ppu_ce = 1'b0; bus_if.prg_read = 1'b0;
    bus_if.prg_write = 1'b0; bus_if.chr_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic chr_rd(input logic [13:0] a);
    bus_if.ppu_ce = 1'b1; bus_if.chr_read = 1'b1; bus_if.chr_ain = a;
    tick();
    idle_bus();
  endtask

  task automatic line(input logic [13:0] a);
    for (int i = 0; i < 3; i++) chr_rd(a);
  endtask

  task automatic ce_tick();
    bus_if.ce = 1'b1;
    tick();
    idle_bus();
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bus_if.ce = 1'b1; bus_if.prg_write = 1'b1; bus_if.prg_ain = a; bus_if.prg_din = d;
    tick();
    idle_bus();
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    bus_if.ce = 1'b1; bus_if.prg_read = 1'b1; bus_if.prg_ain = a;
    #1 d = bus_if.prg_dout;
    tick();
    idle_bus();
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d, output logic h);
    bus_if.prg_ain = a;
    #1;
    d = bus_if.prg_dout;
    h = bus_if.has_dout;
  endtask

  initial begin
    logic [7:0] d;
    logic       h;

    pv[0]  = '{14'h2000, 1'b0, 8'd0};
    pv[1]  = '{14'h2000, 1'b0, 8'd0};
    pv[2]  = '{14'h2000, 1'b1, 8'd0};
    pv[3]  = '{14'h2000, 1'b1, 8'd0};
    pv[4]  = '{14'h2040, 1'b1, 8'd0};
    pv[5]  = '{14'h2040, 1'b1, 8'd0};
    pv[6]  = '{14'h2040, 1'b1, 8'd1};
    pv[7]  = '{14'h1000, 1'b1, 8'd1};
    pv[8]  = '{14'h1000, 1'b1, 8'd1};
    pv[9]  = '{14'h1000, 1'b1, 8'd1};
    pv[10] = '{14'h2040, 1'b1, 8'd1};
    pv[11] = '{14'h3000, 1'b1, 8'd1};

    rv[0] = '{BASE - 16'd1, 8'hFF, 1'b0};
    rv[1] = '{BASE,         8'hFF, 1'b0};
    rv[2] = '{BASE + 16'd1, 8'h40, 1'b1};
    rv[3] = '{BASE + 16'd3, 8'h40, 1'b1};
    rv[4] = '{BASE + 16'd4, 8'h01, 1'b1};
    rv[5] = '{BASE + 16'd5, 8'hFF, 1'b0};

    idle_bus();
    bus_if.prg_ain = 16'h0000; bus_if.prg_din = 8'h00; bus_if.chr_ain = 14'h0000;
    tick();
    do_reset();

    // reset then idle
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_in_frame", 16'(in_frame), 16'h0);
    chk("rst_scanline", 16'(scanline), 16'h0);
    cpu_rd(BASE + 16'd1, d);
    chk("rst_status0", 16'(d), 16'h00);
    peek(BASE - 16'd1, d, h);
    chk("rst_outside_dout", 16'(d), 16'hFF);
    chk("rst_outside_has", 16'(h), 16'h0);

    // line detection table
    for (int i = 0; i < 12; i++) begin
      chr_rd(pv[i].addr);
      chk($sformatf("ppu%0d_in_frame", i), 16'(in_frame), 16'(pv[i].exp_if));
      chk($sformatf("ppu%0d_scanline", i), 16'(scanline), 16'(pv[i].exp_sl));
    end

    // register decode table (ce low, nothing cleared)
    for (int i = 0; i < 6; i++) begin
      peek(rv[i].addr, d, h);
      chk($sformatf("reg%0d_dout", i), 16'(d), 16'(rv[i].exp_dout));
      chk($sformatf("reg%0d_has", i), 16'(h), 16'(rv[i].exp_has));
    end

    // IRQ on channel 1 at line 5
    do_reset();
    cpu_wr(BASE + 16'd2, 8'd5);
    cpu_wr(BASE + 16'd3, 8'h80);
    for (int n = 0; n < 5; n++) line(14'h2000 + 14'(n * 64));
    chk("irq_before_line5", 16'(irq), 16'h0);
    line(14'h2000 + 14'(5 * 64));
    chk("irq_line5", 16'(irq), 16'h1);
    chk("irq_scanline5", 16'(scanline), 16'd5);
    cpu_rd(BASE + 16'd3, d);
    chk("irq_status_first", 16'(d), 16'hC0);
    cpu_rd(BASE + 16'd3, d);
    chk("irq_status_second", 16'(d), 16'h40);
    chk("irq_cleared", 16'(irq), 16'h0);

    // masking: pending without enable
    do_reset();
    cpu_wr(BASE + 16'd2, 8'd5);
    for (int n = 0; n < 6; n++) line(14'h2000 + 14'(n * 64));
    chk("mask_irq_low", 16'(irq), 16'h0);
    peek(BASE + 16'd3, d, h);
    chk("mask_status", 16'(d), 16'hC0);
    cpu_wr(BASE + 16'd3, 8'h80);
    chk("mask_enable_irq", 16'(irq), 16'h1);

    // frame exit after IDLE_TIMEOUT ce cycles
    chr_rd(14'h0100);
    ce_tick();
    ce_tick();
    chk("exit_hold", 16'(in_frame), 16'h1);
    ce_tick();
    chk("exit_in_frame", 16'(in_frame), 16'h0);
    chk("exit_scanline", 16'(scanline), 16'h0);

    // read coinciding with the would-be timeout edge keeps the frame
    line(14'h2000);
    line(14'h2040);
    chk("reenter_scanline", 16'(scanline), 16'd1);
    ce_tick();
    ce_tick();
    bus_if.ce = 1'b1; bus_if.ppu_ce = 1'b1; bus_if.chr_read = 1'b1; bus_if.chr_ain = 14'h0100;
    tick();
    idle_bus();
    chk("timeout_read_in_frame", 16'(in_frame), 16'h1);
    chk("timeout_read_scanline", 16'(scanline), 16'd1);
    ce_tick();
    ce_tick();
    chk("timeout_restart_hold", 16'(in_frame), 16'h1);
    ce_tick();
    chk("timeout_restart_exit", 16'(in_frame), 16'h0);

    // pending set and status read on the same edge
    do_reset();
    cpu_wr(BASE, 8'd1);
    line(14'h2000);
    chr_rd(14'h2040);
    chr_rd(14'h2040);
    bus_if.ce = 1'b1; bus_if.prg_read = 1'b1; bus_if.prg_ain = BASE + 16'd1;
    bus_if.ppu_ce = 1'b1; bus_if.chr_read = 1'b1; bus_if.chr_ain = 14'h2040;
    #1 d = bus_if.prg_dout;
    chk("collide_read", 16'(d), 16'h40);
    tick();
    idle_bus();
    chk("collide_scanline", 16'(scanline), 16'd1);
    peek(BASE + 16'd1, d, h);
    chk("collide_pending_kept", 16'(d), 16'hC0);

    // async reset mid-line
    cpu_wr(BASE + 16'd1, 8'h80);
    chk("pre_reset_irq", 16'(irq), 16'h1);
    chr_rd(14'h2080);
    chr_rd(14'h2080);
    reset = 1'b1;
    #2;
    chk("async_irq", 16'(irq), 16'h0);
    chk("async_in_frame", 16'(in_frame), 16'h0);
    chk("async_scanline", 16'(scanline), 16'h0);
    peek(BASE + 16'd1, d, h);
    chk("async_status", 16'(d), 16'h00);
    reset = 1'b0;
    tick();
    chr_rd(14'h2080);
    chr_rd(14'h2080);
    chk("restart_two_reads", 16'(in_frame), 16'h0);
    chr_rd(14'h2080);
    chk("restart_third_read", 16'(in_frame), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
